uart_tx_arbiter: RTL

- Round-robin arbiter and sequencer that shares one Transmitter instance between NUM_REQ byte requesters.
- Grants one requester at a time and drives the Transmitter's send and data_in, holding data_in stable for the whole frame.
- Tracks active_flag and done_flag to detect frame completion, and returns a per-requester done or timeout error.
- Owns the parity_type/baud_rate configuration and changes it only between frames.

---
 rtl/uart_tx_arbiter_pkg.sv | 29 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the Transmitter arbiter: FSM states and line configuration codes.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    WAIT_ACTIVE = 3'd2,
    WAIT_DONE   = 3'd3,
    RELEASE     = 3'd4
  } state_t;

  // Parity-type codes understood by the Transmitter.
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;
  localparam logic [1:0] PARITY_MARK = 2'b11;

  // Baud-rate codes understood by the Transmitter.
  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef struct packed {
    logic [1:0] parity;
    logic [1:0] baud;
  } cfg_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  int pos;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!valid && req[pos]) begin
        valid      = 1'b1;
        grant[pos] = 1'b1;
        idx        = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Transmitter among NUM_REQ byte requesters: round-robin grant, frame sequencing,
// start timeout, and configuration changes deferred to idle time.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 65535,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic                   cfg_wr,
  input  logic [1:0]             cfg_parity_type,
  input  logic [1:0]             cfg_baud_rate,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   busy,
  output logic                   tx_send,
  output logic [7:0]             tx_data,
  output logic [1:0]             tx_parity_type,
  output logic [1:0]             tx_baud_rate,
  input  logic                   tx_active_flag,
  input  logic                   tx_done_flag
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 cfg_pend;
  cfg_t                 cfg_hold;

  logic [NUM_REQ-1:0]   win_grant;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // NOTE: all state here is registered with non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      grant          <= '0;
      done           <= '0;
      err            <= '0;
      busy           <= 1'b0;
      tx_send        <= 1'b0;
      tx_data        <= 8'h00;
      tx_parity_type <= PARITY_NONE;
      tx_baud_rate   <= BAUD_2400;
      ptr            <= '0;
      cnt            <= '0;
      cfg_pend       <= 1'b0;
      cfg_hold       <= '0;
    end else begin
      done <= '0;
      err  <= '0;

      // Writes during a frame wait here; the newest one wins.
      if (cfg_wr && state != IDLE) begin
        cfg_pend <= 1'b1;
        cfg_hold <= '{parity: cfg_parity_type, baud: cfg_baud_rate};
      end

      unique case (state)
        IDLE: begin
          if (cfg_wr) begin
            tx_parity_type <= cfg_parity_type;
            tx_baud_rate   <= cfg_baud_rate;
            cfg_pend       <= 1'b0;
          end else if (cfg_pend) begin
            tx_parity_type <= cfg_hold.parity;
            tx_baud_rate   <= cfg_hold.baud;
            cfg_pend       <= 1'b0;
          end else if (win_valid) begin
            grant   <= win_grant;
            tx_data <= req_data[8*int'(win_idx) +: 8];
            ptr     <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          tx_send <= 1'b1;
          cnt     <= '0;
          state   <= WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          // send is seen on the slow baud clock, so it stays high until the Transmitter reacts.
          if (tx_active_flag) begin
            tx_send <= 1'b0;
            state   <= WAIT_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == TIMEOUT_LAST) begin
              tx_send <= 1'b0;
              err     <= grant;
              state   <= RELEASE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_active_flag && tx_done_flag) begin
            done  <= grant;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
